instruction_queue_register: RTL

//  Parametrised successor to the SAP-1 instruction register. Holds up to DEPTH fetched

---
 rtl/instruction_queue_register.sv | 110 +++++++++++
 1 files changed

// File: rtl/instruction_queue_register.sv
// Circular prefetch queue of instruction words; head entry drives opcode and operand.
// Flush empties the queue, overflow is sticky until clr.
module instruction_queue_register #(
  parameter int unsigned       WORD_W    = 8,
  parameter int unsigned       OP_W      = 4,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WORD_W-1:0] HALT_WORD = 8'hFF,
  localparam int unsigned      CNT_W     = $clog2(DEPTH + 1),
  localparam int unsigned      PTR_W     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   Li,
  input  logic [WORD_W-1:0]      busIn,
  input  logic                   Adv,
  input  logic                   Flush,
  input  logic                   Ei,
  output logic [WORD_W-OP_W-1:0] busOut,
  output logic [OP_W-1:0]        opCode,
  output logic                   valid,
  output logic                   full,
  output logic [CNT_W-1:0]       count,
  output logic                   overflow
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              pop_ok, push_ok;
  logic [WORD_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop_ok     = 1'b0;
    push_ok    = 1'b0;
    if (Flush) begin
      // Pending Adv is meaningless once the queue is discarded.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      if (Li) begin
        mem_d[wr_ptr_q] = busIn;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
        count_d         = CNT_W'(1);
      end
    end else begin
      pop_ok  = Adv && (count_q != '0);
      // A pop on a full queue frees the slot the push lands in.
      push_ok = Li && ((count_q != CNT_W'(DEPTH)) || pop_ok);
      if (push_ok) begin
        mem_d[wr_ptr_q] = busIn;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (Li && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left untouched by clr.
  always_ff @(posedge clk) begin
    if (!clr) begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    valid    = (count_q != '0);
    full     = (count_q == CNT_W'(DEPTH));
    count    = count_q;
    overflow = overflow_q;
    head     = valid ? mem_q[rd_ptr_q] : HALT_WORD;
    opCode   = head[WORD_W-1 -: OP_W];
  end

  assign busOut = Ei ? head[WORD_W-OP_W-1:0] : 'z;

endmodule
